// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - sequential radix-2 unsigned multiply/divide unit
module mul_div_unit #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    dst,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [AW-1:0]    wpa,
    output logic             wr,
    output logic             dbz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] LAST_ITER = 5'd16;

    state_t           state;
    logic [4:0]       cnt;
    logic [1:0]       op_q;
    logic [AW-1:0]    dst_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    // hi/lo: product upper/lower half for MUL, remainder/quotient for DIV
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             is_div;
    logic             div_zero;
    logic [WIDTH-1:0] final_res;

    assign is_div   = op_q[1];
    assign div_zero = is_div && (b_q == '0);

    // One radix-2 iteration: shift-add for MUL, restoring shift-subtract for DIV
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        hi_next   = hi;
        lo_next   = lo;
        if (!is_div) begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo[WIDTH-1:1]};
        end else if (div_shift >= {1'b0, b_q}) begin
            hi_next = div_diff[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_next = div_shift[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b0};
        end
    end

    // Select the half or field requested by the captured op; zero divisor is forced explicitly
    always_comb begin
        final_res = '0;
        case (op_q)
            2'b00: final_res = lo;
            2'b01: final_res = hi;
            2'b10: final_res = div_zero ? '1 : lo;
            2'b11: final_res = div_zero ? a_q : hi;
            default: final_res = '0;
        endcase
    end

    // Control FSM with registered handshake outputs and result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            dst_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            wr     <= 1'b0;
            dbz    <= 1'b0;
            result <= '0;
            wpa    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    wr   <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        op_q  <= op;
                        dst_q <= dst;
                        a_q   <= a;
                        b_q   <= b;
                        hi    <= '0;
                        // MUL consumes the multiplier from lo; DIV shifts the dividend out of lo
                        lo    <= op[1] ? a : b;
                        busy  <= 1'b1;
                        dbz   <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == LAST_ITER) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        wr     <= 1'b1;
                        result <= final_res;
                        wpa    <= dst_q;
                        dbz    <= div_zero;
                    end else begin
                        hi  <= hi_next;
                        lo  <= lo_next;
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    wr    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    wr    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;

    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] dst;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [AW-1:0] wpa;
    logic          wr;
    logic          dbz;

    mul_div_unit #(.WIDTH(W), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dst(dst),
        .busy(busy), .done(done), .result(result), .wpa(wpa), .wr(wr), .dbz(dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  res;
        logic [AW-1:0] adr;
        logic          z;
        int            edge0;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [W-1:0] last_res = '0;
    logic         last_z   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: plain arithmetic on the operands
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic [AW-1:0] d);
        exp_t e;
        logic [2*W-1:0] p;
        p = 32'(x) * 32'(y);
        e.adr = d;
        e.z = 1'b0;
        e.edge0 = 0;
        case (o)
            2'd0: e.res = p[W-1:0];
            2'd1: e.res = p[2*W-1:W];
            2'd2: begin e.z = (y == 0); e.res = (y == 0) ? 16'hFFFF : W'(x / y); end
            default: begin e.z = (y == 0); e.res = (y == 0) ? x : W'(x % y); end
        endcase
        return e;
    endfunction

    // Monitor: every write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && wr) begin
            if (exp_q.size() == 0) begin
                check("stray_wr", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("wpa", wpa, e.adr);
                check("dbz", dbz, e.z);
                check("done_eq_wr", done, wr);
                check("latency", cyc, e.edge0 + 17);
                last_res = e.res;
                last_z   = e.z;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("idle_timeout", n, 0);
    endtask

    // Caller guarantees DUT is idle at the current negedge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [AW-1:0] d);
        exp_t e;
        e = model(o, x, y, d);
        e.edge0 = cyc + 1;
        op = o; a = x; b = y; dst = d; start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        op = 2'($urandom);
        dst = AW'($urandom);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wr"}, wr, 0);
        check({tag, "_dbz"}, dbz, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_wpa"}, wpa, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; dst = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Directed cases
        issue(2'd0, 16'd300, 16'd200, 3'd3);   wait_idle();
        check("hold_result", result, 16'hEA60);
        issue(2'd1, 16'hFFFF, 16'hFFFF, 3'd1); wait_idle();
        issue(2'd0, 16'hFFFF, 16'hFFFF, 3'd2); wait_idle();
        issue(2'd2, 16'd1000, 16'd7, 3'd4);    wait_idle();
        issue(2'd3, 16'd1000, 16'd7, 3'd5);    wait_idle();
        issue(2'd2, 16'h1234, 16'd0, 3'd6);    wait_idle();
        check("dbz_hold", dbz, 1);
        issue(2'd3, 16'h1234, 16'd0, 3'd7);    wait_idle();
        issue(2'd0, 16'd5, 16'd9, 3'd0);       wait_idle();
        check("dbz_cleared", dbz, 0);

        // Start during RUN and DONE is ignored; start right after DONE is accepted
        issue(2'd1, 16'h8001, 16'h7FFF, 3'd2);
        repeat (4) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        begin
            int n = 0;
            while (!done && n < 30) begin @(negedge clk); n++; end
            check("done_seen", done, 1);
        end
        start = 1'b1; @(negedge clk); start = 1'b0;
        check("done_start_ignored", busy, 0);
        issue(2'd2, 16'hBEEF, 16'd13, 3'd3);
        check("b2b_accepted", busy, 1);
        wait_idle();

        // Reset during RUN aborts without a write and beats start
        issue(2'd0, 16'd1234, 16'd77, 3'd5);
        repeat (7) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_zero("abort");
        repeat (25) @(negedge clk);
        check("abort_no_wr_idle", busy, 0);

        // Randomised operations against the model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            issue(2'($urandom), W'($urandom), rb, AW'($urandom));
            wait_idle();
            check("rand_hold", result, last_res);
            check("rand_dbz_hold", dbz, last_z);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
